// File: rtl/uart_runner_if.sv
// Serial pins and receive/status strobes of the UART echo block.
// The slave side is the echo block; the master side is the host/board.
interface uart_runner_if;
   logic       rx_i;
   logic       tx_o;
   logic       rx_valid_o;
   logic [7:0] rx_data_o;
   logic       frame_err_o;
   logic       overflow_o;

   modport slave (
      input  rx_i,
      output tx_o, rx_valid_o, rx_data_o, frame_err_o, overflow_o
   );

   modport master (
      output rx_i,
      input  tx_o, rx_valid_o, rx_data_o, frame_err_o, overflow_o
   );
endinterface

// File: rtl/uart_runner.sv
// 8N1 UART echo: synchronized receiver -> byte FIFO -> transmitter; start bit leaves 2 cycles after rx_valid_o.
// No backpressure on the serial input: a good byte arriving while the FIFO is full is dropped and flagged.
module uart_runner #(
   parameter int CLKS_PER_BIT = 280,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   uart_runner_if.slave  bus
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [AW:0]   CNT_FULL = (AW + 1)'(FIFO_DEPTH);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_DATA  = 2'd2;
   localparam logic [1:0] ST_STOP  = 2'd3;

   logic          rx_meta_q, rx_sync_q, rx_prev_q;
   logic [1:0]    rx_state_q, rx_state_d;
   logic [CW-1:0] rx_cnt_q, rx_cnt_d;
   logic [2:0]    rx_idx_q, rx_idx_d;
   logic [7:0]    rx_shift_q, rx_shift_d;
   logic [7:0]    rx_data_q;
   logic          rx_valid_q, frame_err_q, overflow_q;

   logic [7:0]    fifo_mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]   fifo_cnt_q, fifo_cnt_d;

   logic [1:0]    tx_state_q, tx_state_d;
   logic [CW-1:0] tx_cnt_q, tx_cnt_d;
   logic [2:0]    tx_idx_q, tx_idx_d;
   logic [7:0]    tx_byte_q, tx_byte_d;
   logic          tx_q;

   logic rx_stop_hit, rx_push, rx_ferr, push_ok, push_drop;
   logic fifo_empty, fifo_full, fifo_pop, tx_bit;

   // ---------------- state registers ----------------
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rx_meta_q   <= 1'b1;
         rx_sync_q   <= 1'b1;
         rx_prev_q   <= 1'b1;
         rx_state_q  <= ST_IDLE;
         rx_cnt_q    <= '0;
         rx_idx_q    <= '0;
         rx_shift_q  <= '0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
         overflow_q  <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         fifo_cnt_q  <= '0;
         tx_state_q  <= ST_IDLE;
         tx_cnt_q    <= '0;
         tx_idx_q    <= '0;
         tx_byte_q   <= '0;
         tx_q        <= 1'b1;
      end else begin
         rx_meta_q   <= bus.rx_i;
         rx_sync_q   <= rx_meta_q;
         rx_prev_q   <= rx_sync_q;
         rx_state_q  <= rx_state_d;
         rx_cnt_q    <= rx_cnt_d;
         rx_idx_q    <= rx_idx_d;
         rx_shift_q  <= rx_shift_d;
         rx_valid_q  <= push_ok;
         frame_err_q <= rx_ferr;
         overflow_q  <= push_drop;
         if (push_ok) rx_data_q <= rx_shift_q;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         fifo_cnt_q  <= fifo_cnt_d;
         tx_state_q  <= tx_state_d;
         tx_cnt_q    <= tx_cnt_d;
         tx_idx_q    <= tx_idx_d;
         tx_byte_q   <= tx_byte_d;
         tx_q        <= tx_bit;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_ok) fifo_mem_q[wr_ptr_q] <= rx_shift_q;
   end

   // ---------------- receiver next state ----------------
   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q + 1'b1;
      rx_idx_d   = rx_idx_q;
      rx_shift_d = rx_shift_q;
      case (rx_state_q)
         ST_IDLE: begin
            rx_cnt_d = '0;
            rx_idx_d = '0;
            if (rx_prev_q && !rx_sync_q) rx_state_d = ST_START;
         end
         ST_START: begin
            if (rx_cnt_q == CNT_HALF) begin
               rx_cnt_d   = '0;
               rx_state_d = rx_sync_q ? ST_IDLE : ST_DATA;
            end
         end
         ST_DATA: begin
            if (rx_cnt_q == CNT_LAST) begin
               rx_cnt_d   = '0;
               rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
               rx_idx_d   = rx_idx_q + 3'd1;
               if (rx_idx_q == 3'd7) rx_state_d = ST_STOP;
            end
         end
         default: begin
            if (rx_cnt_q == CNT_LAST) begin
               rx_cnt_d   = '0;
               rx_state_d = ST_IDLE;
            end
         end
      endcase
   end

   // ---------------- receiver outputs and FIFO ----------------
   always_comb begin
      rx_stop_hit = (rx_state_q == ST_STOP) && (rx_cnt_q == CNT_LAST);
      rx_push     = rx_stop_hit && rx_sync_q;
      rx_ferr     = rx_stop_hit && !rx_sync_q;
      fifo_empty  = (fifo_cnt_q == '0);
      fifo_full   = (fifo_cnt_q == CNT_FULL);
      // A pop in the same cycle frees the slot, so a push on a full FIFO is still accepted.
      push_ok     = rx_push && (!fifo_full || fifo_pop);
      push_drop   = rx_push && fifo_full && !fifo_pop;
   end

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      fifo_cnt_d = fifo_cnt_q;
      if (push_ok)  wr_ptr_d = wr_ptr_q + 1'b1;
      if (fifo_pop) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_ok, fifo_pop})
         2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
         2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
         default: fifo_cnt_d = fifo_cnt_q;
      endcase
   end

   // ---------------- transmitter next state ----------------
   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q + 1'b1;
      tx_idx_d   = tx_idx_q;
      tx_byte_d  = tx_byte_q;
      case (tx_state_q)
         ST_IDLE: begin
            tx_cnt_d = '0;
            tx_idx_d = '0;
            if (!fifo_empty) begin
               tx_state_d = ST_START;
               tx_byte_d  = fifo_mem_q[rd_ptr_q];
            end
         end
         ST_START: begin
            if (tx_cnt_q == CNT_LAST) begin
               tx_cnt_d   = '0;
               tx_idx_d   = '0;
               tx_state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            if (tx_cnt_q == CNT_LAST) begin
               tx_cnt_d = '0;
               tx_idx_d = tx_idx_q + 3'd1;
               if (tx_idx_q == 3'd7) tx_state_d = ST_STOP;
            end
         end
         default: begin
            // Chain straight into the next start bit so queued bytes leave with no idle gap.
            if (tx_cnt_q == CNT_LAST) begin
               tx_cnt_d = '0;
               if (!fifo_empty) begin
                  tx_state_d = ST_START;
                  tx_byte_d  = fifo_mem_q[rd_ptr_q];
               end else begin
                  tx_state_d = ST_IDLE;
               end
            end
         end
      endcase
   end

   // ---------------- transmitter outputs ----------------
   always_comb begin
      fifo_pop = !fifo_empty &&
                 ((tx_state_q == ST_IDLE) || ((tx_state_q == ST_STOP) && (tx_cnt_q == CNT_LAST)));
      case (tx_state_q)
         ST_START: tx_bit = 1'b0;
         ST_DATA:  tx_bit = tx_byte_q[tx_idx_q];
         default:  tx_bit = 1'b1;
      endcase
   end

   assign bus.tx_o        = tx_q;
   assign bus.rx_valid_o  = rx_valid_q;
   assign bus.rx_data_o   = rx_data_q;
   assign bus.frame_err_o = frame_err_q;
   assign bus.overflow_o  = overflow_q;
endmodule

// File: tb/tb_uart_runner.sv
// Host-side UART model driving uart_runner with random bytes and bit rates; echoes and
// status strobes are compared against an expected-byte queue model.
module tb_uart_runner;
   localparam int CPB   = 16;
   localparam int DEPTH = 4;
   localparam int TCLK  = 100;
   localparam int NOM   = CPB * TCLK;
   localparam int FRAME = 10 * CPB;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #(TCLK / 2) clk = ~clk;

   uart_runner_if bus ();

   uart_runner #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   logic [7:0] tx_got[$];
   int         tx_fall[$];
   logic [7:0] rx_got[$];
   int         rx_cyc[$];
   logic [7:0] exp_tx[$];
   logic [7:0] exp_rx[$];
   int exp_ferr = 0, exp_ovf = 0;
   int ferr_cnt = 0, ovf_cnt = 0, wide_cnt = 0, glitch_cnt = 0;
   bit pv = 0, pf = 0, po = 0;

   logic samp [FRAME];
   logic [7:0] mon_b;
   int   mon_start;
   bit   mon_ok;

   task automatic chk(input string tag, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Strobe monitor: records every accepted byte and counts status pulses and over-wide pulses.
   initial forever begin
      @(negedge clk);
      if (bus.rx_valid_o) begin
         rx_got.push_back(bus.rx_data_o);
         rx_cyc.push_back(cyc);
      end
      if (bus.frame_err_o) ferr_cnt++;
      if (bus.overflow_o)  ovf_cnt++;
      if ((bus.rx_valid_o && pv) || (bus.frame_err_o && pf) || (bus.overflow_o && po)) wide_cnt++;
      pv = bus.rx_valid_o;
      pf = bus.frame_err_o;
      po = bus.overflow_o;
   end

   // Host receiver: samples every cycle of a frame; each bit must hold for exactly CPB cycles.
   initial forever begin
      @(negedge clk);
      if (rst_n && bus.tx_o == 1'b0) begin
         mon_start = cyc;
         mon_ok    = 1'b1;
         for (int j = 0; j < FRAME; j++) begin
            if (j > 0) @(negedge clk);
            if (!rst_n) begin
               mon_ok = 1'b0;
               break;
            end
            samp[j] = bus.tx_o;
         end
         if (mon_ok) begin
            for (int j = 0; j < FRAME; j++)
               if (samp[j] !== samp[(j / CPB) * CPB + CPB / 2]) glitch_cnt++;
            for (int k = 0; k < 8; k++) mon_b[k] = samp[(k + 1) * CPB + CPB / 2];
            if (samp[CPB / 2] !== 1'b0 || samp[9 * CPB + CPB / 2] !== 1'b1) glitch_cnt++;
            tx_got.push_back(mon_b);
            tx_fall.push_back(mon_start);
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int bit_t);
      bus.rx_i = 1'b0;
      #(bit_t);
      for (int i = 0; i < 8; i++) begin
         bus.rx_i = b[i];
         #(bit_t);
      end
      bus.rx_i = stop_bit;
      #(bit_t);
      bus.rx_i = 1'b1;
   endtask

   // Well-framed byte on an idle-capable path: it must be received and echoed.
   task automatic send_good(input logic [7:0] b, input int bit_t);
      send_byte(b, 1'b1, bit_t);
      exp_rx.push_back(b);
      exp_tx.push_back(b);
   endtask

   task automatic wait_echo();
      for (int c = 0; c < 30 * FRAME && tx_got.size() < exp_tx.size(); c++) @(negedge clk);
      repeat (FRAME + 2 * CPB) @(negedge clk);
   endtask

   task automatic finish_scenario(input string tag);
      wait_echo();
      chk({tag, " echo count"}, tx_got.size(), exp_tx.size());
      for (int i = 0; i < exp_tx.size(); i++)
         chk($sformatf("%s echo[%0d]", tag, i),
             (i < tx_got.size()) ? int'(tx_got[i]) : -1, int'(exp_tx[i]));
      chk({tag, " rx_valid count"}, rx_got.size(), exp_rx.size());
      for (int i = 0; i < exp_rx.size(); i++)
         chk($sformatf("%s rx_data[%0d]", tag, i),
             (i < rx_got.size()) ? int'(rx_got[i]) : -1, int'(exp_rx[i]));
      chk({tag, " frame_err pulses"}, ferr_cnt, exp_ferr);
      chk({tag, " overflow pulses"}, ovf_cnt, exp_ovf);
      chk({tag, " pulse width"}, wide_cnt, 0);
      chk({tag, " tx bit shape"}, glitch_cnt, 0);
      tx_got.delete(); tx_fall.delete(); rx_got.delete(); rx_cyc.delete();
      exp_tx.delete(); exp_rx.delete();
      exp_ferr = 0; exp_ovf = 0; ferr_cnt = 0; ovf_cnt = 0; wide_cnt = 0; glitch_cnt = 0;
   endtask

   initial begin
      #(60000 * TCLK);
      $display("FAIL watchdog: simulation did not finish within 60000 cycles");
      $fatal(1);
   end

   initial begin
      logic [7:0] b;
      logic [7:0] ovf_bytes [5];
      int         n, per, w;

      bus.rx_i = 1'b1;
      rst_n    = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset tx_o", int'(bus.tx_o), 1);
      chk("reset rx_valid_o", int'(bus.rx_valid_o), 0);
      chk("reset frame_err_o", int'(bus.frame_err_o), 0);
      chk("reset overflow_o", int'(bus.overflow_o), 0);
      chk("reset rx_data_o", int'(bus.rx_data_o), 0);
      rst_n = 1'b1;
      repeat (100) @(negedge clk);
      chk("idle tx_o", int'(bus.tx_o), 1);

      // Basic echo, with the 2-cycle rx_valid -> start-bit latency.
      send_good(8'h41, NOM);
      wait_echo();
      chk("basic echo latency",
          (tx_fall.size() > 0 && rx_cyc.size() > 0) ? tx_fall[0] - rx_cyc[0] : -1, 2);
      finish_scenario("basic");

      // Back-to-back at the fast edge of tolerance: frames must leave with no gap.
      send_good(8'h00, 1540);
      send_good(8'hFF, 1540);
      send_good(8'h55, 1540);
      send_good(8'hA3, 1540);
      wait_echo();
      for (int i = 1; i < 4; i++)
         chk($sformatf("b2b frame spacing[%0d]", i),
             (i < tx_fall.size()) ? tx_fall[i] - tx_fall[i-1] : -1, FRAME);
      finish_scenario("b2b");

      // Framing error, then a clean byte.
      send_byte(8'h3C, 1'b0, NOM);
      exp_ferr = 1;
      #(NOM);
      send_good(8'h12, NOM);
      finish_scenario("framing");

      // Glitches shorter than half a bit.
      for (int g = 0; g < 4; g++) begin
         w = $urandom_range(1, 5);
         bus.rx_i = 1'b0;
         #(w * TCLK + $urandom_range(0, TCLK - 1));
         bus.rx_i = 1'b1;
         repeat (3 * CPB) @(negedge clk);
      end
      chk("glitch tx_o idle", int'(bus.tx_o), 1);
      finish_scenario("glitch");

      // Random bursts at random bit periods within +/-3.75%.
      for (int r = 0; r < 4; r++) begin
         n = $urandom_range(1, 6);
         for (int k = 0; k < n; k++) begin
            b   = 8'($urandom);
            per = $urandom_range(1540, 1660);
            send_good(b, per);
            if ($urandom_range(0, 1) == 1) #($urandom_range(1, 2 * NOM));
         end
         finish_scenario($sformatf("random%0d", r));
      end

      // Reset while the echo is in data bit 4.
      b = 8'($urandom);
      send_good(b, NOM);
      exp_tx.delete();
      for (int c = 0; c < 4 * FRAME && bus.tx_o; c++) @(negedge clk);
      chk("rstmid start bit seen", int'(bus.tx_o), 0);
      repeat (5 * CPB + CPB / 2) @(negedge clk);
      #(TCLK / 5);
      rst_n = 1'b0;
      #(TCLK / 10);
      chk("rstmid tx_o async high", int'(bus.tx_o), 1);
      repeat (3) @(negedge clk);
      chk("rstmid tx_o in reset", int'(bus.tx_o), 1);
      rst_n = 1'b1;
      repeat (2 * CPB) @(negedge clk);
      send_good(8'h7E, NOM);
      finish_scenario("rstmid");

      // Stall the transmitter: four bytes fit, the fifth overflows.
      force dut.tx_state_q = 2'd3;
      force dut.tx_cnt_q   = '0;
      for (int k = 0; k < 5; k++) begin
         ovf_bytes[k] = 8'($urandom);
         send_byte(ovf_bytes[k], 1'b1, NOM);
         if (k < DEPTH) begin
            exp_rx.push_back(ovf_bytes[k]);
            exp_tx.push_back(ovf_bytes[k]);
         end else begin
            exp_ovf++;
         end
      end
      repeat (2 * CPB) @(negedge clk);
      chk("ovf no echo while stalled", tx_got.size(), 0);
      chk("ovf pulse at 5th byte", ovf_cnt, 1);
      release dut.tx_state_q;
      release dut.tx_cnt_q;
      finish_scenario("overflow");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
